// File: rtl/cog_ctr_pkg.sv
// Shared encodings, state enumeration and payload layout for the cog counter
// configuration sequencer.
package cog_ctr_pkg;

    localparam int PAY_W  = 96;
    localparam int DATA_W = 32;

    localparam logic [1:0] OP_CTR  = 2'b00;
    localparam logic [1:0] OP_FRQ  = 2'b01;
    localparam logic [1:0] OP_PHS  = 2'b10;
    localparam logic [1:0] OP_FULL = 2'b11;

    localparam int PAY_CTR_HI = 95;
    localparam int PAY_CTR_LO = 64;
    localparam int PAY_FRQ_HI = 63;
    localparam int PAY_FRQ_LO = 32;
    localparam int PAY_PHS_HI = 31;
    localparam int PAY_PHS_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_Q0   = 3'd2,
        ST_FRQ  = 3'd3,
        ST_PHS  = 3'd4,
        ST_CTR  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    typedef struct packed {
        logic              id;
        logic              sel;
        logic [1:0]        op;
        logic [PAY_W-1:0]  pay;
    } cmd_t;

    // Payload field written by a single-field op; FULL has no single field.
    function automatic logic [DATA_W-1:0] pay_field(input logic [PAY_W-1:0] pay,
                                                    input logic [1:0] op);
        logic [DATA_W-1:0] f;
        case (op)
            OP_CTR:  f = pay[PAY_CTR_HI:PAY_CTR_LO];
            OP_FRQ:  f = pay[PAY_FRQ_HI:PAY_FRQ_LO];
            OP_PHS:  f = pay[PAY_PHS_HI:PAY_PHS_LO];
            default: f = 32'h0000_0000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/cog_ctr_seq_if.sv
// Requester handshake plus counter write-port bundle of the sequencer.
interface cog_ctr_seq_if;
    import cog_ctr_pkg::*;

    logic              ena;
    logic              req0_valid;
    logic              req1_valid;
    logic              req0_ready;
    logic              req1_ready;
    logic              req0_sel;
    logic              req1_sel;
    logic [1:0]        req0_op;
    logic [1:0]        req1_op;
    logic [PAY_W-1:0]  req0_pay;
    logic [PAY_W-1:0]  req1_pay;
    logic [DATA_W-1:0] data;
    logic              a_setctr;
    logic              a_setfrq;
    logic              a_setphs;
    logic              b_setctr;
    logic              b_setfrq;
    logic              b_setphs;
    logic              done;
    logic              done_id;
    logic              busy;

    modport master (
        output ena, req0_valid, req1_valid, req0_sel, req1_sel,
               req0_op, req1_op, req0_pay, req1_pay,
        input  req0_ready, req1_ready, data,
               a_setctr, a_setfrq, a_setphs, b_setctr, b_setfrq, b_setphs,
               done, done_id, busy
    );

    modport slave (
        input  ena, req0_valid, req1_valid, req0_sel, req1_sel,
               req0_op, req1_op, req0_pay, req1_pay,
        output req0_ready, req1_ready, data,
               a_setctr, a_setfrq, a_setphs, b_setctr, b_setfrq, b_setphs,
               done, done_id, busy
    );

endinterface

// File: rtl/cog_ctr_arb.sv
// Two-way requester arbiter: round-robin on last grant or fixed port-0 priority.
module cog_ctr_arb
    import cog_ctr_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk_cog,
    input  logic       res,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic       grant_id,
    output logic [1:0] grant_oh
);

    logic last_grant_r;

    // Grant selection; one-hot is empty when nobody is requesting.
    always_comb begin
        grant_id = 1'b0;
        grant_oh = 2'b00;
        case (valid)
            2'b01: begin
                grant_id = 1'b0;
                grant_oh = 2'b01;
            end
            2'b10: begin
                grant_id = 1'b1;
                grant_oh = 2'b10;
            end
            2'b11: begin
                if (RR_EN) begin
                    grant_id = ~last_grant_r;
                end else begin
                    grant_id = 1'b0;
                end
                grant_oh = grant_id ? 2'b10 : 2'b01;
            end
            default: begin
                grant_id = 1'b0;
                grant_oh = 2'b00;
            end
        endcase
    end

    // Reset to 1 so that port 0 wins the first contention.
    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            last_grant_r <= 1'b1;
        end else if (advance) begin
            last_grant_r <= grant_id;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/cog_ctr_seq.sv
// Counter A/B configuration sequencer: arbitrates two requesters and emits one
// write strobe per cycle, including the quiesced FULL program sequence.
module cog_ctr_seq
    import cog_ctr_pkg::*;
#(
    parameter bit QUIESCE_EN = 1'b1,
    parameter bit RR_EN      = 1'b1
) (
    input  logic         clk_cog,
    input  logic         res,
    cog_ctr_seq_if.slave bus
);

    state_t            state_r;
    state_t            state_nxt_s;
    cmd_t              cmd_r;
    cmd_t              cmd_nxt_s;
    logic              grant_id_s;
    logic [1:0]        grant_oh_s;
    logic [1:0]        valid_s;
    logic              arb_en_s;
    logic              accept_s;
    logic [2:0]        fld_s;
    logic [DATA_W-1:0] data_s;
    logic              done_s;

    assign valid_s  = {bus.req1_valid, bus.req0_valid};
    assign arb_en_s = (state_r == ST_IDLE) & bus.ena & ~res;
    assign accept_s = arb_en_s & (|valid_s);

    cog_ctr_arb #(.RR_EN(RR_EN)) u_arb (
        .clk_cog  (clk_cog),
        .res      (res),
        .valid    (valid_s),
        .advance  (accept_s),
        .grant_id (grant_id_s),
        .grant_oh (grant_oh_s)
    );

    assign bus.req0_ready = arb_en_s & grant_oh_s[0];
    assign bus.req1_ready = arb_en_s & grant_oh_s[1];

    // Command captured from whichever port the arbiter picked.
    always_comb begin
        cmd_nxt_s = cmd_r;
        if (grant_id_s) begin
            cmd_nxt_s.id  = 1'b1;
            cmd_nxt_s.sel = bus.req1_sel;
            cmd_nxt_s.op  = bus.req1_op;
            cmd_nxt_s.pay = bus.req1_pay;
        end else begin
            cmd_nxt_s.id  = 1'b0;
            cmd_nxt_s.sel = bus.req0_sel;
            cmd_nxt_s.op  = bus.req0_op;
            cmd_nxt_s.pay = bus.req0_pay;
        end
    end

    // Next-state logic; dropping ena sends every state back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.ena) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (cmd_nxt_s.op != OP_FULL) begin
                            state_nxt_s = ST_WR;
                        end else if (QUIESCE_EN) begin
                            state_nxt_s = ST_Q0;
                        end else begin
                            state_nxt_s = ST_FRQ;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WR:   state_nxt_s = ST_DONE;
                ST_Q0:   state_nxt_s = ST_FRQ;
                ST_FRQ:  state_nxt_s = ST_PHS;
                ST_PHS:  state_nxt_s = ST_CTR;
                ST_CTR:  state_nxt_s = ST_DONE;
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Field strobe {phs,frq,ctr} and data decode, gated by ena in the same cycle.
    always_comb begin
        fld_s  = 3'b000;
        data_s = 32'h0000_0000;
        done_s = 1'b0;
        if (bus.ena) begin
            case (state_r)
                ST_WR: begin
                    case (cmd_r.op)
                        OP_CTR:  fld_s = 3'b001;
                        OP_FRQ:  fld_s = 3'b010;
                        OP_PHS:  fld_s = 3'b100;
                        default: fld_s = 3'b000;
                    endcase
                    data_s = pay_field(cmd_r.pay, cmd_r.op);
                end
                ST_Q0: begin
                    fld_s  = 3'b001;
                    data_s = 32'h0000_0000;
                end
                ST_FRQ: begin
                    fld_s  = 3'b010;
                    data_s = cmd_r.pay[PAY_FRQ_HI:PAY_FRQ_LO];
                end
                ST_PHS: begin
                    fld_s  = 3'b100;
                    data_s = cmd_r.pay[PAY_PHS_HI:PAY_PHS_LO];
                end
                ST_CTR: begin
                    fld_s  = 3'b001;
                    data_s = cmd_r.pay[PAY_CTR_HI:PAY_CTR_LO];
                end
                ST_DONE: done_s = 1'b1;
                default: begin
                    fld_s  = 3'b000;
                    data_s = 32'h0000_0000;
                    done_s = 1'b0;
                end
            endcase
        end else begin
            fld_s  = 3'b000;
            data_s = 32'h0000_0000;
            done_s = 1'b0;
        end
    end

    assign bus.a_setctr = fld_s[0] & ~cmd_r.sel;
    assign bus.a_setfrq = fld_s[1] & ~cmd_r.sel;
    assign bus.a_setphs = fld_s[2] & ~cmd_r.sel;
    assign bus.b_setctr = fld_s[0] &  cmd_r.sel;
    assign bus.b_setfrq = fld_s[1] &  cmd_r.sel;
    assign bus.b_setphs = fld_s[2] &  cmd_r.sel;
    assign bus.data     = data_s;
    assign bus.done     = done_s;
    assign bus.done_id  = done_s & cmd_r.id;
    assign bus.busy     = (state_r != ST_IDLE);

    // State and command registers.
    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            state_r <= ST_IDLE;
            cmd_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                cmd_r <= cmd_nxt_s;
            end else begin
                cmd_r <= cmd_r;
            end
        end
    end

endmodule
